// File: rtl/shift_cmd_queue.sv
// Command FIFO in front of the barrel shifter: buffers {data, amt, dir, mode} commands,
// drops reserved-mode commands, and presents the oldest entry straight to the shifter inputs.
module shift_cmd_queue #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [2:0]    in_amt,
    input  logic          in_dir,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  d_in,
    output logic [2:0]    sft_amt,
    output logic          sft_dir,
    output logic [1:0]    mode,
    output logic [AW:0]   count,
    output logic          drop
);

    localparam int unsigned EW      = N + 6;
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          drop_q, drop_d;
    logic          push_fire, pop_fire, store;
    logic [EW-1:0] head;

    // Ready depends only on stored count, never on out_ready.
    always_comb begin
        in_ready  = (count_q != FullCnt);
        out_valid = (count_q != '0);
        push_fire = in_valid && in_ready;
        store     = push_fire && (in_mode != 2'b11);
        pop_fire  = out_valid && out_ready;
        drop_d    = push_fire && (in_mode == 2'b11);
    end

    always_comb begin
        mem_d = mem_q;
        if (store) begin
            mem_d[wr_ptr_q] = {in_data, in_amt, in_dir, in_mode};
        end
    end

    always_comb begin
        wr_ptr_d = store    ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({store, pop_fire})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Idle head reads all-zero so the shifter sees a stable command.
    always_comb begin
        head = out_valid ? mem_q[rd_ptr_q] : '0;
        {d_in, sft_amt, sft_dir, mode} = head;
        count = count_q;
        drop  = drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
